heston_mul_pipe: RTL and testbench

//  Parametrised, pipelined multiplier for the hestonEuro datapath, generalising the single-cycle
//  32s x 32ns product. Configurable operand/result widths, latency and signedness, optional

---
 rtl/heston_mul_pipe.sv | 106 ++++++++++
 tb/tb_heston_mul_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/heston_mul_pipe.sv
// Pipelined multiplier for the hestonEuro datapath: multiply in stage 1, retime in the middle,
// scale and wrap/saturate in the final stage. The whole pipe stalls on downstream backpressure.
module heston_mul_pipe #(
    parameter int A_W       = 32,
    parameter int B_W       = 32,
    parameter int OUT_W     = 32,
    parameter int NUM_STAGE = 3,
    parameter int SIGNED0   = 1,
    parameter int SIGNED1   = 0,
    parameter int OUT_SHIFT = 0,
    parameter int SATURATE  = 0
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   din0,
    input  logic [B_W-1:0]   din1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] dout,
    output logic             ovf
);

    localparam int PW  = A_W + B_W + 1;
    localparam bit SGN = (SIGNED0 != 0) || (SIGNED1 != 0);

    localparam logic signed [PW-1:0] ONE  = PW'(1);
    localparam logic signed [PW-1:0] MAXV = SGN ? (ONE <<< (OUT_W - 1)) - ONE
                                                : (ONE <<< OUT_W) - ONE;
    localparam logic signed [PW-1:0] MINV = SGN ? -(ONE <<< (OUT_W - 1)) : '0;

    logic                    adv;
    logic                    accept;
    logic [NUM_STAGE:1]      vld_pipe;
    logic                    fin_vld;
    logic signed [PW-1:0]    a_ext;
    logic signed [PW-1:0]    b_ext;
    logic signed [PW-1:0]    prod_in;
    logic signed [PW-1:0]    fin_p;
    logic signed [PW-1:0]    shifted;
    logic                    hi;
    logic                    lo;
    logic [OUT_W-1:0]        res;
    logic                    res_ovf;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign accept    = in_valid && adv;
    assign out_valid = vld_pipe[NUM_STAGE];

    // One extra bit keeps signed x unsigned products exact.
    assign a_ext   = (SIGNED0 != 0) ? PW'($signed(din0)) : PW'(din0);
    assign b_ext   = (SIGNED1 != 0) ? PW'($signed(din1)) : PW'(din1);
    assign prod_in = a_ext * b_ext;

    generate
        if (NUM_STAGE == 1) begin : g_direct
            assign fin_p   = prod_in;
            assign fin_vld = accept;
        end else begin : g_retime
            logic signed [PW-1:0] prod_q [1:NUM_STAGE-1];

            always_ff @(posedge ap_clk) begin
                if (adv) begin
                    prod_q[1] <= prod_in;
                    for (int i = 2; i < NUM_STAGE; i++)
                        prod_q[i] <= prod_q[i-1];
                end
            end

            assign fin_p   = prod_q[NUM_STAGE-1];
            assign fin_vld = vld_pipe[NUM_STAGE-1];
        end
    endgenerate

    always_comb begin
        shifted = fin_p >>> OUT_SHIFT;
        hi      = shifted > MAXV;
        lo      = shifted < MINV;
        res_ovf = hi || lo;
        res     = shifted[OUT_W-1:0];
        if (SATURATE != 0 && hi)
            res = MAXV[OUT_W-1:0];
        else if (SATURATE != 0 && lo)
            res = MINV[OUT_W-1:0];
    end

    // Output registers only load on a real result, so bubbles leave dout untouched.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            vld_pipe <= '0;
            dout     <= '0;
            ovf      <= 1'b0;
        end else if (adv) begin
            vld_pipe[1] <= accept;
            for (int i = 2; i <= NUM_STAGE; i++)
                vld_pipe[i] <= vld_pipe[i-1];
            if (fin_vld) begin
                dout <= res;
                ovf  <= res_ovf;
            end
        end
    end

endmodule

// File: tb/tb_heston_mul_pipe.sv
// Bench for heston_mul_pipe: five parameterisations share one stimulus stream and are each
// scored against a plain-arithmetic model of scale/wrap/saturate behaviour.
module tb_heston_mul_pipe;

    localparam int ND = 5;
    localparam int NSV  [ND] = '{3, 3, 3, 1, 8};
    localparam int S1V  [ND] = '{0, 0, 0, 1, 1};
    localparam int SHV  [ND] = '{0, 0, 16, 0, 0};
    localparam int SATV [ND] = '{0, 1, 0, 0, 0};

    typedef struct {
        logic [31:0] d;
        logic        o;
        int          cyc;
    } exp_t;

    typedef struct {
        int          k;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        o;
    } vec_t;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] din0;
    logic [31:0] din1;
    logic        rdy [ND];
    logic        ov  [ND];
    logic [31:0] dt  [ND];
    logic        of  [ND];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    bit mon_en = 0;
    bit chk_lat = 0;
    exp_t q [ND][$];
    int   popcnt [ND];
    logic pv [ND];
    logic [31:0] pd [ND];
    logic po [ND];
    logic pr;

    always #5 ap_clk = ~ap_clk;

    heston_mul_pipe u0 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .din0(din0), .din1(din1), .out_valid(ov[0]), .out_ready(out_ready), .dout(dt[0]), .ovf(of[0]));
    heston_mul_pipe #(.SATURATE(1)) u1 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid),
        .in_ready(rdy[1]), .din0(din0), .din1(din1), .out_valid(ov[1]), .out_ready(out_ready),
        .dout(dt[1]), .ovf(of[1]));
    heston_mul_pipe #(.OUT_SHIFT(16)) u2 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid),
        .in_ready(rdy[2]), .din0(din0), .din1(din1), .out_valid(ov[2]), .out_ready(out_ready),
        .dout(dt[2]), .ovf(of[2]));
    heston_mul_pipe #(.NUM_STAGE(1), .SIGNED1(1)) u3 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .in_valid(in_valid), .in_ready(rdy[3]), .din0(din0), .din1(din1), .out_valid(ov[3]),
        .out_ready(out_ready), .dout(dt[3]), .ovf(of[3]));
    heston_mul_pipe #(.NUM_STAGE(8), .SIGNED1(1)) u4 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .in_valid(in_valid), .in_ready(rdy[4]), .din0(din0), .din1(din1), .out_valid(ov[4]),
        .out_ready(out_ready), .dout(dt[4]), .ovf(of[4]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Exact product in wide integers, then floor-shift and range/clamp rules.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int k);
        logic signed [127:0] pa, pb, p, s;
        logic signed [127:0] mx, mn;
        exp_t e;
        pa = $signed(a);
        if (S1V[k] != 0) pb = $signed(b);
        else pb = $signed({96'd0, b});
        p  = pa * pb;
        s  = p >>> SHV[k];
        mx = 128'sd2147483647;
        mn = -128'sd2147483648;
        e.o = (s > mx) || (s < mn);
        e.d = s[31:0];
        if (SATV[k] != 0 && s > mx) e.d = 32'h7FFF_FFFF;
        if (SATV[k] != 0 && s < mn) e.d = 32'h8000_0000;
        e.cyc = cycle;
        return e;
    endfunction

    task automatic mon();
        exp_t e;
        for (int k = 0; k < ND; k++) begin
            if (ov[k] && out_ready) begin
                if (q[k].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result dut%0d actual=%h required=none", k, dt[k]);
                end else begin
                    e = q[k].pop_front();
                    chk($sformatf("dout_dut%0d", k), dt[k], e.d);
                    chk($sformatf("ovf_dut%0d", k), 32'(of[k]), 32'(e.o));
                    if (chk_lat) chk($sformatf("latency_dut%0d", k), 32'(cycle - e.cyc), 32'(NSV[k]));
                end
                popcnt[k]++;
            end
            if (pv[k] && !pr) begin
                chk($sformatf("hold_dout_dut%0d", k), dt[k], pd[k]);
                chk($sformatf("hold_ovf_dut%0d", k), 32'(of[k]), 32'(po[k]));
            end
            if (in_valid && rdy[k]) q[k].push_back(model(din0, din1, k));
            pv[k] = ov[k];
            pd[k] = dt[k];
            po[k] = of[k];
        end
        pr = out_ready;
    endtask

    task automatic cyc();
        @(negedge ap_clk);
        if (mon_en) mon();
        @(posedge ap_clk);
        #1;
        cycle++;
    endtask

    task automatic rand_op();
        logic [31:0] corner [5];
        corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        din0 = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
        din1 = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
    endtask

    vec_t vt [10];
    logic [31:0] sa [10];
    logic [31:0] sb [10];
    int op;

    initial begin
        ap_rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; din0 = '0; din1 = '0;
        for (int k = 0; k < ND; k++) begin popcnt[k] = 0; pv[k] = 0; pd[k] = '0; po[k] = 0; end
        pr = 1'b1;

        vt[0] = '{0, 32'hFFFF_FFFD, 32'h5,         32'hFFFF_FFF1, 1'b0};
        vt[1] = '{0, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};
        vt[2] = '{1, 32'h2,         32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1};
        vt[3] = '{2, 32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 1'b0};
        vt[4] = '{0, 32'h8000_0000, 32'h1,         32'h8000_0000, 1'b0};
        vt[5] = '{1, 32'h8000_0000, 32'h2,         32'h8000_0000, 1'b1};
        vt[6] = '{0, 32'h4000_0000, 32'h2,         32'h8000_0000, 1'b1};
        vt[7] = '{1, 32'h4000_0000, 32'h2,         32'h7FFF_FFFF, 1'b1};
        vt[8] = '{2, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 1'b0};
        vt[9] = '{0, 32'h0,         32'hDEAD_BEEF, 32'h0,         1'b0};

        repeat (2) cyc();
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("rst_valid_dut%0d", k), 32'(ov[k]), 32'h0);
            chk($sformatf("rst_dout_dut%0d", k), dt[k], 32'h0);
            chk($sformatf("rst_ovf_dut%0d", k), 32'(of[k]), 32'h0);
        end
        ap_rst_n = 1'b1;
        cyc();
        for (int k = 0; k < ND; k++) chk($sformatf("rst_ready_dut%0d", k), 32'(rdy[k]), 32'h1);

        // Directed vectors: single op, exact-cycle arrival.
        for (int v = 0; v < 10; v++) begin
            in_valid = 1'b1; din0 = vt[v].a; din1 = vt[v].b;
            cyc();
            in_valid = 1'b0;
            for (int e = 1; e < NSV[vt[v].k]; e++) begin
                chk($sformatf("vec%0d_early_valid", v), 32'(ov[vt[v].k]), 32'h0);
                cyc();
            end
            chk($sformatf("vec%0d_valid", v), 32'(ov[vt[v].k]), 32'h1);
            chk($sformatf("vec%0d_dout", v), dt[vt[v].k], vt[v].d);
            chk($sformatf("vec%0d_ovf", v), 32'(of[vt[v].k]), 32'(vt[v].o));
            repeat (2) cyc();
        end

        // Reset with ops in flight.
        repeat (10) cyc();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin din0 = i + 7; din1 = 32'h11; cyc(); end
        in_valid = 1'b0; ap_rst_n = 1'b0;
        cyc();
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("midrst_valid_dut%0d", k), 32'(ov[k]), 32'h0);
            chk($sformatf("midrst_dout_dut%0d", k), dt[k], 32'h0);
        end
        ap_rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            for (int k = 0; k < ND; k++)
                chk($sformatf("stale_valid_dut%0d", k), 32'(ov[k]), 32'h0);
            cyc();
        end

        // Stream of 10 with a 4-cycle backpressure window.
        mon_en = 1;
        for (int i = 0; i < 10; i++) begin sa[i] = $urandom; sb[i] = $urandom_range(1, 1000); end
        op = 0;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 5 && c < 9);
            in_valid  = (op < 10);
            din0 = sa[op % 10]; din1 = sb[op % 10];
            @(negedge ap_clk);
            if (c <= 12) chk("stream_in_ready", 32'(rdy[0]), 32'(out_ready));
            if (in_valid && rdy[0]) op++;
            mon();
            @(posedge ap_clk);
            #1;
            cycle++;
        end
        chk("stream_count", 32'(popcnt[0]), 32'd10);
        for (int k = 0; k < ND; k++) chk($sformatf("stream_drain_dut%0d", k), 32'(q[k].size()), 32'h0);

        // Random, free-flowing output: exact latency per parameterisation.
        chk_lat = 1; out_ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            rand_op();
            cyc();
        end
        in_valid = 1'b0;
        repeat (12) cyc();
        for (int k = 0; k < ND; k++) chk($sformatf("rand_drain_dut%0d", k), 32'(q[k].size()), 32'h0);

        // Random with random backpressure.
        chk_lat = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            rand_op();
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (12) cyc();
        for (int k = 0; k < ND; k++) chk($sformatf("stall_drain_dut%0d", k), 32'(q[k].size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
